// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed neuron layer sequencer.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } seq_state_t;

    // Strictly positive two's-complement values pass; zero and negatives clamp to 0.
    function automatic logic [63:0] relu64(input logic [63:0] s);
        logic [63:0] r;
        if (!s[63] && (s != 64'd0)) begin
            r = s;
        end else begin
            r = 64'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_mac_acc.sv
// Single shared multiply-accumulate register; acc_sum exposes the value the
// register takes on the next edge so the final product can be folded in early.
module nn_mac_acc
    import nn_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] acc_sum
);

    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] prod_s;

    // Truncated unsigned product and the next accumulator value.
    always_comb begin
        prod_s = x_data * w_data;
        if (acc_en) begin
            acc_sum = acc_r + prod_s;
        end else begin
            acc_sum = acc_r;
        end
    end

    // Accumulator register, cleared at the start of every neuron.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {DATA_W{1'b0}};
        end else if (clear) begin
            acc_r <= {DATA_W{1'b0}};
        end else begin
            acc_r <= acc_sum;
        end
    end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Walks every (neuron, input) pair of a layer through one shared MAC and
// streams one ReLU result per neuron on a valid/ready interface.
module neuron_layer_sequencer
    import nn_pkg::*;
#(
    parameter int INPUT_COUNT  = 4,
    parameter int NEURON_COUNT = 4,
    parameter int DATA_W       = 64,
    localparam int XA_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1,
    localparam int NA_W = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1,
    localparam int WA_W = ((INPUT_COUNT * NEURON_COUNT) > 1) ?
                          $clog2(INPUT_COUNT * NEURON_COUNT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [XA_W-1:0]   x_addr,
    input  logic [DATA_W-1:0] x_data,
    output logic [WA_W-1:0]   w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [NA_W-1:0]   b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NA_W-1:0]   out_index
);

    localparam logic [XA_W-1:0] I_LAST = XA_W'(INPUT_COUNT - 1);
    localparam logic [NA_W-1:0] N_LAST = NA_W'(NEURON_COUNT - 1);

    seq_state_t        state_r;
    logic              pv_r;
    logic              clear_s;
    logic [DATA_W-1:0] acc_sum_s;
    logic [DATA_W-1:0] sum_s;

    // Accumulator is cleared on every entry into MAC (pv is always 0 then).
    always_comb begin
        clear_s = 1'b0;
        if ((state_r == IDLE) && start) begin
            clear_s = 1'b1;
        end else if ((state_r == EMIT) && out_ready) begin
            clear_s = 1'b1;
        end else begin
            clear_s = 1'b0;
        end
    end

    assign sum_s = acc_sum_s + b_data;

    nn_mac_acc #(
        .DATA_W (DATA_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .acc_en  (pv_r),
        .x_data  (x_data),
        .w_data  (w_data),
        .acc_sum (acc_sum_s)
    );

    // Sequencer FSM; x_addr doubles as the input counter and b_addr as the neuron counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            pv_r      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            x_addr    <= {XA_W{1'b0}};
            w_addr    <= {WA_W{1'b0}};
            b_addr    <= {NA_W{1'b0}};
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_index <= {NA_W{1'b0}};
        end else begin
            pv_r <= rd_en;
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= MAC;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        x_addr  <= {XA_W{1'b0}};
                        w_addr  <= {WA_W{1'b0}};
                        b_addr  <= {NA_W{1'b0}};
                    end
                end
                MAC: begin
                    if (x_addr == I_LAST) begin
                        state_r <= DRAIN;
                        rd_en   <= 1'b0;
                    end else begin
                        x_addr <= x_addr + XA_W'(1'b1);
                        w_addr <= w_addr + WA_W'(1'b1);
                    end
                end
                DRAIN: begin
                    // The last product is still in flight, so sample the accumulator's next value.
                    state_r   <= EMIT;
                    out_valid <= 1'b1;
                    out_data  <= relu64(sum_s);
                    out_index <= b_addr;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (b_addr == N_LAST) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r <= MAC;
                            rd_en   <= 1'b1;
                            x_addr  <= {XA_W{1'b0}};
                            w_addr  <= w_addr + WA_W'(1'b1);
                            b_addr  <= b_addr + NA_W'(1'b1);
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    rd_en     <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed self-checking bench for neuron_layer_sequencer (4 inputs x 4 neurons).
module tb_neuron_layer_sequencer;

    localparam logic [63:0] NEG5 = 64'hFFFF_FFFF_FFFF_FFFB;
    localparam logic [63:0] NEG3 = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [1:0]  x_addr;
    logic [63:0] x_data;
    logic [3:0]  w_addr;
    logic [63:0] w_data;
    logic [1:0]  b_addr;
    logic [63:0] b_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_index;

    logic [63:0] x_mem [4];
    logic [63:0] w_mem [16];
    logic [63:0] b_mem [4];

    int n_cmp    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    neuron_layer_sequencer #(
        .INPUT_COUNT  (4),
        .NEURON_COUNT (4),
        .DATA_W       (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .x_addr    (x_addr),
        .x_data    (x_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index)
    );

    // Synchronous-read activation/weight memories, combinational bias memory.
    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= x_mem[x_addr];
            w_data <= w_mem[w_addr];
        end
    end
    assign b_data = b_mem[b_addr];

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!out_valid && (k < budget)) begin
            tick();
            k++;
        end
        check("valid_timeout", 64'(out_valid), 64'd1);
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        x_mem = '{64'd1, 64'd2, 64'd3, 64'd4};
        for (int j = 0; j < 16; j++) w_mem[j] = 64'd0;
        w_mem[0]  = 64'd1; w_mem[1] = 64'd1; w_mem[2] = 64'd1; w_mem[3] = 64'd1;
        w_mem[4]  = NEG5;
        w_mem[15] = 64'd2;
        b_mem = '{64'd0, 64'd2, 64'd0, NEG3};

        repeat (2) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_x_addr", 64'(x_addr), 64'd0);
        check("rst_w_addr", 64'(w_addr), 64'd0);
        check("rst_b_addr", 64'(b_addr), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_index", 64'(out_index), 64'd0);
        rst = 1'b0;
        tick();

        // Pass 1: dot product, negative, zero and negative-bias neurons.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("e0_rd_en", 64'(rd_en), 64'd1);
        check("e0_busy", 64'(busy), 64'd1);
        check("e0_x_addr", 64'(x_addr), 64'd0);
        check("e0_w_addr", 64'(w_addr), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mac_start_ignored", 64'(x_addr), 64'd1);
        tick();
        tick();
        check("e3_x_addr", 64'(x_addr), 64'd3);
        check("e3_w_addr", 64'(w_addr), 64'd3);
        check("e3_rd_en", 64'(rd_en), 64'd1);
        tick();
        check("drain_rd_en", 64'(rd_en), 64'd0);
        check("drain_valid", 64'(out_valid), 64'd0);
        tick();
        check("n0_valid_latency", 64'(out_valid), 64'd1);
        check("n0_data", out_data, 64'd10);
        check("n0_index", 64'(out_index), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("emit_start_valid", 64'(out_valid), 64'd1);
        check("emit_start_index", 64'(out_index), 64'd0);
        check("emit_start_data", out_data, 64'd10);
        check("emit_rd_en", 64'(rd_en), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("n1_valid_low", 64'(out_valid), 64'd0);
        check("n1_rd_en", 64'(rd_en), 64'd1);
        check("n1_b_addr", 64'(b_addr), 64'd1);
        check("n1_w_addr", 64'(w_addr), 64'd4);
        check("n1_x_addr", 64'(x_addr), 64'd0);
        repeat (5) tick();
        check("n1_valid", 64'(out_valid), 64'd1);
        check("n1_index", 64'(out_index), 64'd1);
        check("n1_neg_relu", out_data, 64'd0);
        for (int s = 0; s < 10; s++) begin
            tick();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_index", 64'(out_index), 64'd1);
            check("stall_data", out_data, 64'd0);
            check("stall_rd_en", 64'(rd_en), 64'd0);
            check("stall_w_addr", 64'(w_addr), 64'd7);
            check("stall_b_addr", 64'(b_addr), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        wait_valid(20);
        check("n2_index", 64'(out_index), 64'd2);
        check("n2_zero_relu", out_data, 64'd0);
        tick();
        wait_valid(20);
        check("n3_index", 64'(out_index), 64'd3);
        check("n3_data", out_data, 64'd5);
        check("no_early_done", 64'(done_cnt), 64'd0);

        // Pass 2 operands: 2^63 * 2 wraps to 0, bias 5 survives.
        x_mem = '{MSB, 64'd0, 64'd0, 64'd0};
        w_mem[0] = 64'd2; w_mem[1] = 64'd0; w_mem[2] = 64'd0; w_mem[3] = 64'd0;
        b_mem[0] = 64'd5;

        tick();
        check("p1_done", 64'(done), 64'd1);
        check("p1_idle_busy", 64'(busy), 64'd0);
        check("p1_valid_low", 64'(out_valid), 64'd0);
        check("p1_last_w_addr", 64'(w_addr), 64'd15);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_cycle_start_rd_en", 64'(rd_en), 64'd1);
        check("done_cycle_start_busy", 64'(busy), 64'd1);
        check("done_pulse_width", 64'(done), 64'd0);
        check("p2_b_addr", 64'(b_addr), 64'd0);
        check("p2_w_addr", 64'(w_addr), 64'd0);
        check("p1_done_count", 64'(done_cnt), 64'd1);
        wait_valid(20);
        check("wrap_data", out_data, 64'd5);
        check("wrap_index", 64'(out_index), 64'd0);

        // Async reset in the middle of neuron 2's MAC phase.
        k = 0;
        while (!((b_addr == 2'd2) && rd_en) && (k < 40)) begin
            tick();
            k++;
        end
        check("reach_n2_mac", 64'((b_addr == 2'd2) && rd_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_rd_en", 64'(rd_en), 64'd0);
        check("mid_rst_b_addr", 64'(b_addr), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(20);
        check("post_rst_data", out_data, 64'd5);
        check("post_rst_index", 64'(out_index), 64'd0);
        for (int n = 1; n < 4; n++) begin
            tick();
            wait_valid(20);
            check("p3_index", 64'(out_index), 64'(n));
            check("p3_data", out_data, 64'd0);
        end
        tick();
        check("p3_done", 64'(done), 64'd1);
        @(negedge clk);
        #1;
        check("total_done_count", 64'(done_cnt), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
